cube_frame_loader: RTL and testbench
====================================

# cube_frame_loader

Upstream/downstream companion of the `network` top. It accepts a cube input frame as a byte stream with a valid/ready handshake and packs the bytes into 120-bit words. Once a complete frame is stored, it pulses the network's `load` and streams the frame into the network one word per cycle. It then captures the network's 4-bit move result and returns it to the host through a second valid/ready handshake, with a timeout for a network that never finishes.

## Interface
- `N_WORDS`, default 32: 120-bit words per frame.
- `WORD_W`, default 120: network input word width.
- `TIMEOUT`, default 4096: cycles to wait for `net_valid` after the last streamed word.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `s_valid` in 1: host byte valid.
- `s_ready` out 1: loader accepts a byte.
- `s_data` in 8: host byte.
- `net_load` out 1: one-cycle start pulse, wired to `network.load`.
- `net_d` out WORD_W: frame word, wired to `network.d`.
- `net_valid` in 1: `network.valid`.
- `net_q` in 4: `network.q`.
- `r_valid` out 1: result valid.
- `r_ready` in 1: host accepts result.
- `r_move` out 4: captured move; 4'hF on timeout.
- `r_err` out 1: 1 = timeout result.
- `busy` out 1: high in every state except FILL.

## Operation
- States: FILL, START, STREAM, WAIT, RESULT.
- **FILL:**
  - `s_ready`=1. A byte is accepted when `s_valid && s_ready`.
  - Bytes are packed little-endian: byte k of a word goes to bits [8k+7:8k], k=0..14.
  - The 15th byte completes a word. That word is written to frame RAM at `wr_ptr`, and `wr_ptr` increments.
  - When word `N_WORDS-1` is written, go to START. `s_ready` drops in the same edge.
- **START:** `net_load`=1 for exactly one cycle, then go to STREAM.
- **STREAM:**
  - `net_d` presents words 0..N_WORDS-1 on consecutive cycles, starting the cycle after `net_load`.
  - `net_d`=0 outside STREAM.
  - After the last word, go to WAIT and clear the timeout counter.
- **WAIT:**
  - On the first cycle `net_valid`=1: capture `net_q` into `r_move`, set `r_err`=0, go to RESULT.
  - If the counter reaches `TIMEOUT-1` first: `r_move`=4'hF, `r_err`=1, go to RESULT.
  - If `net_valid` and timeout coincide, `net_valid` wins.
- **RESULT:**
  - `r_valid`=1. `r_move` and `r_err` stay stable until `r_valid && r_ready`.
  - On that handshake, clear the pointers and byte counter and go to FILL.
- `net_valid` outside WAIT is ignored.
- Arithmetic:
  - Byte counter: 0..14, wraps to 0 on word completion.
  - `wr_ptr` and `rd_ptr`: clog2(N_WORDS) bits, no wrap beyond N_WORDS-1.
  - Timeout counter: clog2(TIMEOUT) bits, saturating.
- Reset at any time, including mid-frame or mid-stream:
  - State returns to FILL.
  - All counters and pointers go to 0.
  - The partial frame is discarded; RAM contents are not cleared.

## Timing
- Reset values: `s_ready`=1 (state FILL), `net_load`=0, `net_d`=0, `r_valid`=0, `r_move`=0, `r_err`=0, `busy`=0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `s_valid`/`r_ready`/`net_valid` to any output.
- Last byte accepted at edge T:
  - `net_load` high during cycle T+1.
  - Words on `net_d` during cycles T+2 .. T+1+N_WORDS.
  - WAIT begins at cycle T+2+N_WORDS.
- The RAM read is synchronous, so the read address is prefetched in START.
- `net_valid` sampled high at edge V: `r_valid` is high from cycle V+1.
- Result handshake at edge H: `s_ready` is high from cycle H+1.
- Maximum throughput: one byte per cycle in FILL.

## Structure
- Shared header `loader_data.v` holds:
  - State encodings.
  - `BYTES_PER_WORD`=15.
  - The timeout move code 4'hF.
- One sub-module, `frame_ram`: single-port synchronous RAM, N_WORDS × WORD_W, with write enable, address, write data and registered read data.
- Byte packing, the FSM and the counters live in the top module.

## Test plan
- Reset, then 480 bytes with value (i mod 256), `s_valid` held high:
  - `net_load` pulses exactly once.
  - `net_d` word 0 = bytes 0..14 little-endian, word 31 = bytes 465..479.
  - `s_ready`=0 from the edge after byte 479.
- Model `net_valid` high 10 cycles after the last word with `net_q`=4'd7, `r_ready` held low for 5 cycles:
  - `r_valid`=1 with `r_move`=7, `r_err`=0, stable for all 5 cycles.
  - After `r_ready`, `s_ready`=1 the next cycle.
- `net_valid` never asserted, `TIMEOUT`=16:
  - `r_valid` 16 cycles after WAIT entry, with `r_move`=4'hF, `r_err`=1.
- Random `s_valid` gaps:
  - Identical words to the gap-free run.
  - No byte lost or duplicated across the word boundary at byte 14→15.
- `rst` pulsed after 200 bytes, then a full 480-byte frame:
  - Streamed words match only the new frame.
  - Exactly one `net_load`.
- `rst` asserted during STREAM word 10:
  - `net_load`, `net_d` and `r_valid` drop to 0 asynchronously.
  - `busy`=0 and `s_ready`=1.

Source files
------------

// File: rtl/cube_frame_loader_pkg.sv
// Shared definitions for the cube frame loader: FSM encoding, packing geometry
// and the move code reported when the network never answers.
package cube_frame_loader_pkg;

    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam int         BYTES_PER_WORD = 15;
    localparam int         BYTE_CNT_W     = 4;
    localparam logic [3:0] TIMEOUT_MOVE   = 4'hF;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cube_frame_loader_frame_ram.sv
// Single-port frame store: synchronous write, registered read of the same address.
module frame_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 120,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; stale words are
    // harmless because a frame is always fully rewritten before it is streamed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cube_frame_loader.sv
// Packs a host byte stream into frame words, replays the frame into the network
// after a load pulse, and hands the network's move (or a timeout) back to the host.
module cube_frame_loader
    import cube_frame_loader_pkg::*;
#(
    parameter int N_WORDS = 32,
    parameter int WORD_W  = 120,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              net_load,
    output logic [WORD_W-1:0] net_d,
    input  logic              net_valid,
    input  logic [3:0]        net_q,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [3:0]        r_move,
    output logic              r_err,
    output logic              busy
);

    localparam int PTR_W = ptr_width(N_WORDS);
    localparam int T_W   = ptr_width(TIMEOUT);
    localparam int BUF_W = 8 * (BYTES_PER_WORD - 1);

    localparam logic [PTR_W-1:0]      LAST_WORD = PTR_W'(N_WORDS - 1);
    localparam logic [T_W-1:0]        LAST_TICK = T_W'(TIMEOUT - 1);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    state_t                  state;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [T_W-1:0]          tcnt;
    logic [BUF_W-1:0]        word_buf;

    logic                    accept;
    logic                    word_done;
    logic [PTR_W-1:0]        ram_addr;
    logic [WORD_W-1:0]       ram_wdata;
    logic [WORD_W-1:0]       ram_q;

    // Every handshake and stream output is a pure decode of the state register.
    assign s_ready  = (state == ST_FILL);
    assign net_load = (state == ST_START);
    assign r_valid  = (state == ST_RESULT);
    assign busy     = (state != ST_FILL);
    assign net_d    = (state == ST_STREAM) ? ram_q : '0;

    assign accept    = s_valid && s_ready;
    assign word_done = accept && (byte_cnt == LAST_BYTE);

    // The final byte bypasses the buffer so the word is written on the same edge.
    assign ram_wdata = WORD_W'({s_data, word_buf});

    // STREAM reads one word ahead because the RAM output is registered;
    // START presents address 0 so word 0 is ready on the first STREAM cycle.
    always_comb begin
        ram_addr = rd_ptr;
        case (state)
            ST_FILL:   ram_addr = wr_ptr;
            ST_STREAM: ram_addr = rd_ptr + PTR_W'(1);
            default:   ram_addr = rd_ptr;
        endcase
    end

    frame_ram #(
        .DEPTH (N_WORDS),
        .WIDTH (WORD_W),
        .AW    (PTR_W)
    ) u_frame_ram (
        .clk   (clk),
        .we    (word_done),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FILL;
            byte_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tcnt     <= '0;
            word_buf <= '0;
            r_move   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (word_done) begin
                        byte_cnt <= '0;
                        if (wr_ptr == LAST_WORD) begin
                            state <= ST_START;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end else if (accept) begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= s_data;
                        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                    end
                end

                ST_START: begin
                    state <= ST_STREAM;
                end

                ST_STREAM: begin
                    if (rd_ptr == LAST_WORD) begin
                        state <= ST_WAIT;
                        tcnt  <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                end

                ST_WAIT: begin
                    // A result arriving on the final timeout tick still counts as valid.
                    if (net_valid) begin
                        r_move <= net_q;
                        r_err  <= 1'b0;
                        state  <= ST_RESULT;
                    end else if (tcnt == LAST_TICK) begin
                        r_move <= TIMEOUT_MOVE;
                        r_err  <= 1'b1;
                        state  <= ST_RESULT;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + T_W'(1);
                    end
                end

                ST_RESULT: begin
                    if (r_ready) begin
                        state    <= ST_FILL;
                        byte_cnt <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        tcnt     <= '0;
                    end
                end

                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_frame_loader.sv
// Directed bench for cube_frame_loader: a byte-level scoreboard predicts every
// streamed word, and the network side is modelled inline.
module tb_cube_frame_loader;

    localparam int N_WORDS = 32;
    localparam int WORD_W  = 120;
    localparam int TIMEOUT = 16;
    localparam int N_BYTES = N_WORDS * 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              net_load;
    logic [WORD_W-1:0] net_d;
    logic              net_valid;
    logic [3:0]        net_q;
    logic              r_valid;
    logic              r_ready;
    logic [3:0]        r_move;
    logic              r_err;
    logic              busy;

    logic [WORD_W-1:0] exp_q [$];
    int checks = 0;
    int passed = 0;

    cube_frame_loader #(
        .N_WORDS (N_WORDS),
        .WORD_W  (WORD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .net_load  (net_load),
        .net_d     (net_d),
        .net_valid (net_valid),
        .net_q     (net_q),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_move    (r_move),
        .r_err     (r_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sends nbytes of value (i*mult+ofs) mod 256; optional random idle gaps,
    // always one just before byte 15 to exercise the word boundary.
    task automatic send_bytes(input int nbytes, input int mult, input int ofs,
                              input bit gaps, input bit track, input string tag);
        logic [WORD_W-1:0] acc;
        logic [7:0]        b;
        int                g;
        int                not_ready;
        acc = '0;
        not_ready = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'((i * mult + ofs) % 256);
            if (gaps && (i == 15 || $urandom_range(0, 3) == 0)) begin
                g = $urandom_range(1, 3);
                s_valid = 1'b0;
                s_data  = 8'hAA;
                repeat (g) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = b;
            @(negedge clk);
            if (s_ready !== 1'b1) not_ready++;
            @(posedge clk);
            #1;
            acc[8 * (i % 15) +: 8] = b;
            if (i % 15 == 14) begin
                if (track) exp_q.push_back(acc);
                acc = '0;
            end
        end
        s_valid = 1'b0;
        s_data  = 8'h00;
        chk({tag, " s_ready during fill"}, 128'(not_ready), 128'd0);
    endtask

    // Called just after the edge that accepted the last byte; returns at the
    // negedge of the cycle showing the last word.
    task automatic check_stream(input string tag);
        int loads;
        logic [WORD_W-1:0] exp;
        @(negedge clk);
        chk({tag, " net_load"}, 128'(net_load), 128'd1);
        chk({tag, " s_ready after last byte"}, 128'(s_ready), 128'd0);
        chk({tag, " busy in start"}, 128'(busy), 128'd1);
        loads = int'(net_load);
        for (int k = 0; k < N_WORDS; k++) begin
            @(negedge clk);
            loads += int'(net_load);
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else exp = 'x;
            chk($sformatf("%s word %0d", tag, k), 128'(net_d), 128'(exp));
        end
        chk({tag, " net_load pulses"}, 128'(loads), 128'd1);
        chk({tag, " scoreboard drained"}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic handshake(input string tag);
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        @(negedge clk);
        chk({tag, " s_ready after handshake"}, 128'(s_ready), 128'd1);
        chk({tag, " r_valid after handshake"}, 128'(r_valid), 128'd0);
        chk({tag, " busy after handshake"}, 128'(busy), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        net_valid = 1'b0;
        net_q = 4'h0;
        r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset s_ready", 128'(s_ready), 128'd1);
        chk("reset net_load", 128'(net_load), 128'd0);
        chk("reset net_d", 128'(net_d), 128'd0);
        chk("reset r_valid", 128'(r_valid), 128'd0);
        chk("reset r_move", 128'(r_move), 128'd0);
        chk("reset r_err", 128'(r_err), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Gap-free frame, network answers 7 ten cycles after the last word.
        send_bytes(N_BYTES, 1, 0, 1'b0, 1'b1, "A");
        check_stream("A");
        @(negedge clk);
        chk("A net_d idle in wait", 128'(net_d), 128'd0);
        chk("A busy in wait", 128'(busy), 128'd1);
        repeat (9) @(negedge clk);
        chk("A r_valid before net_valid", 128'(r_valid), 128'd0);
        net_valid = 1'b1;
        net_q = 4'd7;
        @(posedge clk);
        #1;
        net_valid = 1'b0;
        net_q = 4'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("A r_valid hold %0d", c), 128'(r_valid), 128'd1);
            chk($sformatf("A r_move hold %0d", c), 128'(r_move), 128'd7);
            chk($sformatf("A r_err hold %0d", c), 128'(r_err), 128'd0);
            net_valid = (c == 1);
            net_q = (c == 1) ? 4'd3 : 4'd0;
        end
        net_valid = 1'b0;
        handshake("A");

        // Same data with random gaps; network never answers, so timeout fires.
        @(posedge clk);
        #1;
        send_bytes(N_BYTES, 1, 0, 1'b1, 1'b1, "B");
        check_stream("B");
        repeat (TIMEOUT) @(negedge clk);
        chk("B r_valid before timeout", 128'(r_valid), 128'd0);
        @(negedge clk);
        chk("B r_valid at timeout", 128'(r_valid), 128'd1);
        chk("B r_move at timeout", 128'(r_move), 128'hF);
        chk("B r_err at timeout", 128'(r_err), 128'd1);
        handshake("B");

        // Reset after 200 bytes; only the following frame may be streamed.
        @(posedge clk);
        #1;
        send_bytes(200, 1, 100, 1'b0, 1'b0, "C0");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("C s_ready after reset", 128'(s_ready), 128'd1);
        chk("C busy after reset", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        send_bytes(N_BYTES, 3, 1, 1'b0, 1'b1, "C");
        check_stream("C");
        @(negedge clk);
        net_valid = 1'b1;
        net_q = 4'd2;
        @(posedge clk);
        #1;
        net_valid = 1'b0;
        net_q = 4'd0;
        @(negedge clk);
        chk("C r_move", 128'(r_move), 128'd2);
        chk("C r_err", 128'(r_err), 128'd0);
        handshake("C");

        // Asynchronous reset while word 10 is on net_d.
        @(posedge clk);
        #1;
        send_bytes(N_BYTES, 5, 9, 1'b0, 1'b1, "D");
        @(negedge clk);
        chk("D net_load", 128'(net_load), 128'd1);
        repeat (11) @(negedge clk);
        for (int k = 0; k < 10; k++) void'(exp_q.pop_front());
        chk("D word 10 before reset", 128'(net_d), 128'(exp_q.pop_front()));
        rst = 1'b1;
        #1;
        chk("D net_load in reset", 128'(net_load), 128'd0);
        chk("D net_d in reset", 128'(net_d), 128'd0);
        chk("D r_valid in reset", 128'(r_valid), 128'd0);
        chk("D busy in reset", 128'(busy), 128'd0);
        chk("D s_ready in reset", 128'(s_ready), 128'd1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
